// File: rtl/bus_pkg.sv
// Shared types and strobe decode for the multiplexed-bus machine-cycle sequencer.
package bus_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StT1,
        StT2,
        StTw,
        StT3,
        StHold
    } bus_state_t;

    typedef enum logic [1:0] {
        KindMemRd = 2'b00,
        KindMemWr = 2'b01,
        KindIoRd  = 2'b10,
        KindIoWr  = 2'b11
    } req_kind_t;

    localparam logic [1:0] ST_FETCH = 2'b11;
    localparam logic [1:0] ST_READ  = 2'b10;
    localparam logic [1:0] ST_WRITE = 2'b01;
    localparam logic [1:0] ST_IDLE  = 2'b00;

    typedef struct packed {
        logic       ale;
        logic       rd_n;
        logic       wr_n;
        logic       iom_n;
        logic [1:0] status;
        logic       ad_oe;
        logic       hlda;
        logic       bus_float;
    } bus_strobe_t;

    function automatic logic kind_is_write(input req_kind_t kind);
        return (kind == KindMemWr) || (kind == KindIoWr);
    endfunction

    function automatic logic kind_is_io(input req_kind_t kind);
        return (kind == KindIoRd) || (kind == KindIoWr);
    endfunction

    // Pin strobes for a given machine-cycle state and latched request.
    function automatic bus_strobe_t bus_decode(input bus_state_t st, input req_kind_t kind,
                                               input logic fetch);
        bus_strobe_t s;
        logic        wr;
        wr          = kind_is_write(kind);
        s.ale       = 1'b0;
        s.rd_n      = 1'b1;
        s.wr_n      = 1'b1;
        s.iom_n     = 1'b0;
        s.status    = ST_IDLE;
        s.ad_oe     = 1'b0;
        s.hlda      = 1'b0;
        s.bus_float = 1'b0;
        case (st)
            StT1: begin
                s.ale   = 1'b1;
                s.ad_oe = 1'b1;
            end
            StT2, StTw, StT3: begin
                s.rd_n  = wr;
                s.wr_n  = !wr;
                s.ad_oe = wr;
            end
            StHold: begin
                s.hlda      = 1'b1;
                s.bus_float = 1'b1;
            end
            default: ;
        endcase
        if (st inside {StT1, StT2, StTw, StT3}) begin
            s.iom_n  = kind_is_io(kind);
            s.status = wr ? ST_WRITE : (fetch ? ST_FETCH : ST_READ);
        end
        return s;
    endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state counter with optional timeout; MAX_WAIT of zero disables the timeout.
module bus_wait_timer
    import bus_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 0
) (
    input  logic clk,
    input  logic resetn_in,
    input  logic i_clear,
    input  logic i_count,
    output logic o_timeout
);

    localparam int unsigned CntW = (MAX_WAIT == 0) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_WAIT);

    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + CntW'(1);

    always_ff @(posedge clk) begin
        if (!resetn_in) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_count) begin
            r_cnt <= w_cnt_inc;
        end
    end

    // Fires in the TW cycle that would be wait state number MAX_WAIT.
    assign o_timeout = (MAX_WAIT != 0) && i_count && (w_cnt_inc == CntMax);

endmodule

// File: rtl/bus_cycle_unit.sv
// T1/T2/TW/T3 machine-cycle sequencer with READY waits, wait timeout and HOLD/HLDA release.
module bus_cycle_unit
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MAX_WAIT = 0
) (
    input  logic                     clk,
    input  logic                     resetn_in,
    input  logic                     req,
    input  logic [1:0]               req_kind,
    input  logic                     req_fetch,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     req_ack,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    input  logic                     ready,
    input  logic                     hold,
    output logic                     hlda,
    output logic                     bus_float,
    output logic [ADDR_W-DATA_W-1:0] haddress,
    output logic [DATA_W-1:0]        ad_out,
    output logic                     ad_oe,
    input  logic [DATA_W-1:0]        ad_in,
    output logic                     ALE,
    output logic                     RDn,
    output logic                     WRn,
    output logic                     IOMn,
    output logic                     S1,
    output logic                     S0
);

    bus_state_t        r_state;
    bus_state_t        w_state_d;
    req_kind_t         r_kind;
    req_kind_t         w_kind_d;
    logic              r_fetch;
    logic              w_fetch_d;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] w_addr_lo_d;
    logic [DATA_W-1:0] w_wdata_d;
    logic              r_err;
    logic              w_set_err;
    logic              w_timeout;
    logic              w_enter_t1;
    logic              w_in_tw;
    bus_strobe_t       r_strb;
    bus_strobe_t       w_strb_d;
    logic [DATA_W-1:0] r_ad_out;
    logic [DATA_W-1:0] w_ad_out_d;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_rdata;

    assign req_ack = req && !hold && ((r_state == StIdle) || (r_state == StT3));

    assign w_kind_d    = req_ack ? req_kind_t'(req_kind) : r_kind;
    assign w_fetch_d   = req_ack ? (req_fetch && (req_kind == 2'b00)) : r_fetch;
    assign w_addr_lo_d = req_ack ? req_addr[DATA_W-1:0] : r_addr[DATA_W-1:0];
    assign w_wdata_d   = req_ack ? req_wdata : r_wdata;

    assign w_in_tw    = (r_state == StTw);
    assign w_enter_t1 = (w_state_d == StT1);

    bus_wait_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_wait_timer (
        .clk      (clk),
        .resetn_in(resetn_in),
        .i_clear  (w_enter_t1),
        .i_count  (w_in_tw),
        .o_timeout(w_timeout)
    );

    always_comb begin
        w_state_d = r_state;
        w_set_err = 1'b0;
        case (r_state)
            StIdle: begin
                if (hold) begin
                    w_state_d = StHold;
                end else if (req) begin
                    w_state_d = StT1;
                end
            end
            StT1: w_state_d = StT2;
            StT2: w_state_d = ready ? StT3 : StTw;
            StTw: begin
                if (ready) begin
                    w_state_d = StT3;
                end else if (w_timeout) begin
                    w_state_d = StT3;
                    w_set_err = 1'b1;
                end
            end
            // HOLD raised earlier in the cycle is only honoured here.
            StT3: begin
                if (hold) begin
                    w_state_d = StHold;
                end else if (req) begin
                    w_state_d = StT1;
                end else begin
                    w_state_d = StIdle;
                end
            end
            StHold: begin
                if (!hold) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        w_strb_d   = bus_decode(w_state_d, w_kind_d, w_fetch_d);
        w_ad_out_d = '0;
        if (w_state_d == StT1) begin
            w_ad_out_d = w_addr_lo_d;
        end else if (w_strb_d.ad_oe) begin
            w_ad_out_d = w_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn_in) begin
            r_state     <= StIdle;
            r_kind      <= KindMemRd;
            r_fetch     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_err       <= 1'b0;
            r_strb      <= bus_decode(StIdle, KindMemRd, 1'b0);
            r_ad_out    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state <= w_state_d;
            r_kind  <= w_kind_d;
            r_fetch <= w_fetch_d;
            if (req_ack) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_enter_t1) begin
                r_err <= 1'b0;
            end else if (w_set_err) begin
                r_err <= 1'b1;
            end
            r_strb      <= w_strb_d;
            r_ad_out    <= w_ad_out_d;
            r_rsp_valid <= (r_state == StT3);
            r_rsp_err   <= (r_state == StT3) && r_err;
            if ((r_state == StT3) && !kind_is_write(r_kind)) begin
                r_rsp_rdata <= ad_in;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign haddress  = r_addr[ADDR_W-1:DATA_W];
    assign ad_out    = r_ad_out;
    assign ad_oe     = r_strb.ad_oe;
    assign ALE       = r_strb.ale;
    assign RDn       = r_strb.rd_n;
    assign WRn       = r_strb.wr_n;
    assign IOMn      = r_strb.iom_n;
    assign S1        = r_strb.status[1];
    assign S0        = r_strb.status[0];
    assign hlda      = r_strb.hlda;
    assign bus_float = r_strb.bus_float;

endmodule

// File: tb/tb_bus_cycle_unit.sv
// Self-checking bench for bus_cycle_unit: directed scenarios plus randomized transactions.
module tb_bus_cycle_unit;

    localparam int MAXW = 3;
    localparam int NCAP = 10;

    logic        clk = 1'b0;
    logic        resetn_in;
    logic        req;
    logic [1:0]  req_kind;
    logic        req_fetch;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        req_ack;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        ready;
    logic        hold;
    logic        hlda;
    logic        bus_float;
    logic [7:0]  haddress;
    logic [7:0]  ad_out;
    logic        ad_oe;
    logic [7:0]  ad_in;
    logic        ALE, RDn, WRn, IOMn, S1, S0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic       ale;
        logic       rdn;
        logic       wrn;
        logic       oe;
        logic       iom;
        logic [1:0] s;
        logic       valid;
        logic       err;
        logic [7:0] ad;
    } obs_t;

    obs_t       obs       [1:NCAP];
    logic [7:0] obs_hadr  [1:NCAP];
    logic [7:0] obs_rdata [1:NCAP];
    bit         got_ack;

    bus_cycle_unit #(
        .ADDR_W  (16),
        .DATA_W  (8),
        .MAX_WAIT(MAXW)
    ) dut (
        .clk      (clk),
        .resetn_in(resetn_in),
        .req      (req),
        .req_kind (req_kind),
        .req_fetch(req_fetch),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_ack  (req_ack),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .ready    (ready),
        .hold     (hold),
        .hlda     (hlda),
        .bus_float(bus_float),
        .haddress (haddress),
        .ad_out   (ad_out),
        .ad_oe    (ad_oe),
        .ad_in    (ad_in),
        .ALE      (ALE),
        .RDn      (RDn),
        .WRn      (WRn),
        .IOMn     (IOMn),
        .S1       (S1),
        .S0       (S0)
    );

    always #5 clk = ~clk;

    // Expected pins in cycle i after the accepting edge, for k cycles of READY low from T2.
    function automatic obs_t expect_cycle(int i, logic [1:0] kind, logic fetch, int k,
                                          logic [15:0] addr, logic [7:0] wdata);
        obs_t       e;
        int         tw;
        logic       wr;
        logic [1:0] st;
        tw = (k < MAXW) ? k : MAXW;
        wr = kind[0];
        st = wr ? 2'b01 : ((fetch && kind == 2'b00) ? 2'b11 : 2'b10);
        e = '0;
        e.rdn = 1'b1;
        e.wrn = 1'b1;
        if (i == 1) begin
            e.ale = 1'b1;
            e.oe  = 1'b1;
            e.ad  = addr[7:0];
            e.iom = kind[1];
            e.s   = st;
        end else if (i >= 2 && i <= 3 + tw) begin
            e.iom = kind[1];
            e.s   = st;
            e.rdn = wr;
            e.wrn = !wr;
            e.oe  = wr;
            e.ad  = wr ? wdata : 8'h00;
        end else if (i == 4 + tw) begin
            e.valid = 1'b1;
            e.err   = (k > MAXW);
        end
        return e;
    endfunction

    // Issues one request and records NCAP cycles of pin activity; does no checking.
    task automatic run_txn(input logic [1:0] kind, input logic fetch, input logic [15:0] addr,
                           input logic [7:0] wdata, input logic [7:0] rdv, input int k);
        @(negedge clk);
        req = 1'b1; req_kind = kind; req_fetch = fetch; req_addr = addr;
        req_wdata = wdata; ready = 1'b1; hold = 1'b0; ad_in = rdv;
        got_ack = 1'b0;
        for (int t = 0; t < 20 && !got_ack; t++) begin
            #1;
            if (req_ack === 1'b1) got_ack = 1'b1;
            else @(negedge clk);
        end
        for (int i = 1; i <= NCAP; i++) begin
            @(negedge clk);
            req = 1'b0;
            ready = !(i >= 2 && i - 2 < k);
            obs[i] = '{ALE, RDn, WRn, ad_oe, IOMn, {S1, S0}, rsp_valid, rsp_valid & rsp_err,
                       ad_oe ? ad_out : 8'h00};
            obs_hadr[i]  = haddress;
            obs_rdata[i] = rsp_rdata;
        end
        ready = 1'b1;
    endtask

    task automatic test_reset();
        resetn_in = 1'b0; req = 1'b0; req_kind = 2'b00; req_fetch = 1'b0; req_addr = '0;
        req_wdata = '0; ready = 1'b1; hold = 1'b0; ad_in = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ALE, RDn, WRn, IOMn, S1, S0, hlda, bus_float, ad_oe, rsp_valid, rsp_err}
            !== 11'b011_0000_0000) begin
            n_bad++;
            $display("FAIL reset_pins: got %b need %b",
                     {ALE, RDn, WRn, IOMn, S1, S0, hlda, bus_float, ad_oe, rsp_valid, rsp_err},
                     11'b011_0000_0000);
        end
        n_cmp++;
        if ({rsp_rdata, haddress} !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_data: got %h need 0000", {rsp_rdata, haddress});
        end
        resetn_in = 1'b1; req = 1'b1; hold = 1'b1;
        #1;
        n_cmp++;
        if (req_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL ack_under_hold: got %b need 0", req_ack);
        end
        @(negedge clk);
        n_cmp++;
        if ({hlda, bus_float} !== 2'b11) begin
            n_bad++;
            $display("FAIL idle_hold: got %b need 11", {hlda, bus_float});
        end
        hold = 1'b0; req = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (hlda !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_release: got %b need 0", hlda);
        end
    endtask

    task automatic test_fetch();
        obs_t e;
        run_txn(2'b00, 1'b1, 16'h12A5, 8'h00, 8'h3E, 0);
        n_cmp++;
        if (!got_ack) begin n_bad++; $display("FAIL fetch_ack: got 0 need 1"); end
        for (int i = 1; i <= NCAP; i++) begin
            e = expect_cycle(i, 2'b00, 1'b1, 0, 16'h12A5, 8'h00);
            n_cmp++;
            if (obs[i] !== e) begin
                n_bad++;
                $display("FAIL fetch_cycle%0d: got %h need %h", i, obs[i], e);
            end
        end
        n_cmp++;
        if (obs_hadr[1] !== 8'h12) begin
            n_bad++; $display("FAIL fetch_haddr: got %h need 12", obs_hadr[1]);
        end
        n_cmp++;
        if (obs_rdata[4] !== 8'h3E) begin
            n_bad++; $display("FAIL fetch_rdata: got %h need 3e", obs_rdata[4]);
        end
    endtask

    task automatic test_io_write();
        obs_t e;
        run_txn(2'b11, 1'b0, 16'h0040, 8'h5A, 8'h00, 2);
        n_cmp++;
        if (!got_ack) begin n_bad++; $display("FAIL iow_ack: got 0 need 1"); end
        for (int i = 1; i <= NCAP; i++) begin
            e = expect_cycle(i, 2'b11, 1'b0, 2, 16'h0040, 8'h5A);
            n_cmp++;
            if (obs[i] !== e) begin
                n_bad++;
                $display("FAIL iow_cycle%0d: got %h need %h", i, obs[i], e);
            end
        end
        n_cmp++;
        if (obs[6].valid !== 1'b1) begin
            n_bad++; $display("FAIL iow_latency: got %b need 1 at cycle 6", obs[6].valid);
        end
    endtask

    task automatic test_timeout();
        obs_t e;
        run_txn(2'b10, 1'b0, 16'hBEEF, 8'h00, 8'hC4, 9);
        n_cmp++;
        if (!got_ack) begin n_bad++; $display("FAIL tmo_ack: got 0 need 1"); end
        for (int i = 1; i <= NCAP; i++) begin
            e = expect_cycle(i, 2'b10, 1'b0, 9, 16'hBEEF, 8'h00);
            n_cmp++;
            if (obs[i] !== e) begin
                n_bad++;
                $display("FAIL tmo_cycle%0d: got %h need %h", i, obs[i], e);
            end
        end
        n_cmp++;
        if ({obs[7].valid, obs[7].err} !== 2'b11) begin
            n_bad++; $display("FAIL tmo_err: got %b need 11", {obs[7].valid, obs[7].err});
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        req = 1'b1; req_kind = 2'b00; req_fetch = 1'b0; req_addr = 16'h3456;
        ready = 1'b1; hold = 1'b0; ad_in = 8'h77;
        got_ack = 1'b0;
        for (int t = 0; t < 20 && !got_ack; t++) begin
            #1;
            if (req_ack === 1'b1) got_ack = 1'b1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!got_ack) begin n_bad++; $display("FAIL hold_first_ack: got 0 need 1"); end
        repeat (2) @(negedge clk);
        hold = 1'b1;
        n_cmp++;
        if (RDn !== 1'b0) begin n_bad++; $display("FAIL hold_t2_rdn: got %b need 0", RDn); end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({req_ack, RDn} !== 2'b00) begin
            n_bad++; $display("FAIL hold_t3: got %b need 00", {req_ack, RDn});
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({hlda, bus_float, RDn, WRn, ad_oe, req_ack} !== 6'b111100) begin
            n_bad++;
            $display("FAIL hold_enter: got %b need 111100",
                     {hlda, bus_float, RDn, WRn, ad_oe, req_ack});
        end
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 8'h77}) begin
            n_bad++;
            $display("FAIL hold_rsp: got %h need 277", {rsp_valid, rsp_err, rsp_rdata});
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if ({hlda, req_ack, rsp_valid} !== 3'b100) begin
                n_bad++;
                $display("FAIL hold_stay%0d: got %b need 100", c, {hlda, req_ack, rsp_valid});
            end
        end
        hold = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({hlda, bus_float, req_ack} !== 3'b001) begin
            n_bad++;
            $display("FAIL hold_exit: got %b need 001", {hlda, bus_float, req_ack});
        end
        @(negedge clk);
        req = 1'b0;
        n_cmp++;
        if (ALE !== 1'b1) begin n_bad++; $display("FAIL hold_pending_t1: got %b need 1", ALE); end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [3];
        int         ale_cyc [3];
        int         val_cyc [3];
        logic [7:0] vrd [3];
        int         issued, ale_cnt, nv;
        vals = '{8'hA1, 8'hB2, 8'hC3};
        issued = 0; ale_cnt = 0; nv = 0;
        for (int j = 0; j < 3; j++) begin ale_cyc[j] = -100; val_cyc[j] = -100; vrd[j] = 'x; end
        ready = 1'b1; hold = 1'b0; req_kind = 2'b00; req_fetch = 1'b0; ad_in = 8'h00;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (ALE === 1'b1 && ale_cnt < 3) begin
                ale_cyc[ale_cnt] = c; ad_in = vals[ale_cnt]; ale_cnt++;
            end
            if (rsp_valid === 1'b1 && nv < 3) begin
                val_cyc[nv] = c; vrd[nv] = rsp_rdata; nv++;
            end
            req = (issued < 3);
            req_addr = 16'h1000 + 16'(issued << 4);
            #1;
            if (req_ack === 1'b1) issued++;
        end
        req = 1'b0;
        n_cmp++;
        if (nv !== 3) begin n_bad++; $display("FAIL b2b_count: got %0d need 3", nv); end
        for (int j = 0; j < 3; j++) begin
            n_cmp++;
            if (val_cyc[j] - ale_cyc[j] !== 3) begin
                n_bad++;
                $display("FAIL b2b_lat%0d: got %0d need 3", j, val_cyc[j] - ale_cyc[j]);
            end
            n_cmp++;
            if (vrd[j] !== vals[j]) begin
                n_bad++; $display("FAIL b2b_rdata%0d: got %h need %h", j, vrd[j], vals[j]);
            end
            if (j > 0) begin
                n_cmp++;
                if (ale_cyc[j] - ale_cyc[j-1] !== 3) begin
                    n_bad++;
                    $display("FAIL b2b_gap%0d: got %0d need 3", j, ale_cyc[j] - ale_cyc[j-1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req = 1'b1; req_kind = 2'b01; req_fetch = 1'b0; req_addr = 16'h2222;
        req_wdata = 8'h99; ready = 1'b0; hold = 1'b0;
        got_ack = 1'b0;
        for (int t = 0; t < 20 && !got_ack; t++) begin
            #1;
            if (req_ack === 1'b1) got_ack = 1'b1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!got_ack) begin n_bad++; $display("FAIL rmid_ack: got 0 need 1"); end
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (WRn !== 1'b0) begin n_bad++; $display("FAIL rmid_tw_wrn: got %b need 0", WRn); end
        resetn_in = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ALE, RDn, WRn, ad_oe, S1, S0, rsp_valid, hlda} !== 8'b0110_0000) begin
            n_bad++;
            $display("FAIL rmid_pins: got %b need 01100000",
                     {ALE, RDn, WRn, ad_oe, S1, S0, rsp_valid, hlda});
        end
        resetn_in = 1'b1; ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({rsp_valid, WRn, ALE} !== 3'b010) begin
                n_bad++;
                $display("FAIL rmid_quiet%0d: got %b need 010", c, {rsp_valid, WRn, ALE});
            end
        end
        req = 1'b1; req_kind = 2'b00;
        #1;
        n_cmp++;
        if (req_ack !== 1'b1) begin n_bad++; $display("FAIL rmid_idle_ack: got %b need 1", req_ack); end
        @(negedge clk);
        req = 1'b0;
        n_cmp++;
        if (ALE !== 1'b1) begin n_bad++; $display("FAIL rmid_restart: got %b need 1", ALE); end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_random();
        obs_t        e;
        logic [1:0]  kind;
        logic        fetch;
        logic [15:0] addr;
        logic [7:0]  wdata, rdv;
        int          k, tw;
        for (int n = 0; n < 24; n++) begin
            kind  = 2'($urandom_range(0, 3));
            fetch = 1'($urandom_range(0, 1));
            addr  = 16'($urandom);
            wdata = 8'($urandom);
            rdv   = 8'($urandom);
            k     = int'($urandom_range(0, 5));
            tw    = (k < MAXW) ? k : MAXW;
            run_txn(kind, fetch, addr, wdata, rdv, k);
            n_cmp++;
            if (!got_ack) begin n_bad++; $display("FAIL rnd%0d_ack: got 0 need 1", n); end
            for (int i = 1; i <= NCAP; i++) begin
                e = expect_cycle(i, kind, fetch, k, addr, wdata);
                n_cmp++;
                if (obs[i] !== e) begin
                    n_bad++;
                    $display("FAIL rnd%0d_cycle%0d: got %h need %h (kind %0d k %0d)",
                             n, i, obs[i], e, kind, k);
                end
                if (i <= 3 + tw) begin
                    n_cmp++;
                    if (obs_hadr[i] !== addr[15:8]) begin
                        n_bad++;
                        $display("FAIL rnd%0d_haddr%0d: got %h need %h", n, i, obs_hadr[i],
                                 addr[15:8]);
                    end
                end
            end
            if (kind[0] == 1'b0) begin
                n_cmp++;
                if (obs_rdata[4 + tw] !== rdv) begin
                    n_bad++;
                    $display("FAIL rnd%0d_rdata: got %h need %h", n, obs_rdata[4 + tw], rdv);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_io_write();
        test_timeout();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
